// File: rtl/sliding_histogram_cfg_if.sv
// Sample-stream and readback bundle for the sliding-window histogram.
// The master side feeds samples and issues readbacks; the slave side is the histogram.
interface sliding_histogram_cfg_if #(
    parameter int DATA_SIZE = 4,
    parameter int LEN_SIZE  = 7
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data;
    logic                 rd_req;
    logic [DATA_SIZE-1:0] rd_bin;
    logic                 rd_valid;
    logic [LEN_SIZE-1:0]  rd_count;

    modport master (
        output in_valid, in_data, rd_req, rd_bin,
        input  in_ready, rd_valid, rd_count
    );

    modport slave (
        input  in_valid, in_data, rd_req, rd_bin,
        output in_ready, rd_valid, rd_count
    );
endinterface

// File: rtl/sliding_histogram_cfg.sv
// Sliding-window histogram over the last len_q accepted samples, with a clear sweep,
// runtime window length and a two-cycle readback port.
module sliding_histogram_cfg #(
    parameter int DATA_SIZE = 4,
    parameter int DATA_NUM  = 16,
    parameter int MAX_LEN   = 64,
    parameter int ADDR_SIZE = 6,
    parameter int LEN_SIZE  = 7
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic [LEN_SIZE-1:0]  win_len,
    sliding_histogram_cfg_if.slave bus,
    output logic                 win_full,
    output logic [LEN_SIZE-1:0]  fill_cnt,
    output logic                 busy
);
    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [DATA_SIZE-1:0]  sweep_q, sweep_d;
    logic [LEN_SIZE-1:0]   len_q, len_d;
    logic [LEN_SIZE-1:0]   fill_q, fill_d;
    logic [ADDR_SIZE-1:0]  wptr_q, wptr_d;
    logic                  full_q, full_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_SIZE-1:0]  s1_inc_q, s1_inc_d;
    logic                  s1_evict_q, s1_evict_d;
    logic                  rd_p_valid_q, rd_p_valid_d;
    logic [DATA_SIZE-1:0]  rd_p_bin_q, rd_p_bin_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [LEN_SIZE-1:0]   rd_count_q, rd_count_d;
    logic [LEN_SIZE-1:0]   cnt_q [DATA_NUM];
    logic [LEN_SIZE-1:0]   cnt_d [DATA_NUM];
    logic [DATA_SIZE-1:0]  fifo_mem [MAX_LEN];
    logic [DATA_SIZE-1:0]  fifo_rdata_q;

    logic                  accept;
    logic                  evict_now;
    logic                  upd;
    logic [ADDR_SIZE-1:0]  rd_addr;
    logic [LEN_SIZE-1:0]   len_sane;
    logic                  inc_ovf;
    logic                  dec_unf;

    assign bus.in_ready = (state_q == S_RUN) && !clr;
    assign accept       = bus.in_valid && bus.in_ready;
    assign evict_now    = (fill_q == len_q);
    // Sample leaving the window: len_q accepts back; reads old data when len_q == MAX_LEN.
    assign rd_addr      = wptr_q - len_q[ADDR_SIZE-1:0];
    assign len_sane     = (win_len == '0 || win_len > LEN_SIZE'(MAX_LEN)) ? LEN_SIZE'(MAX_LEN) : win_len;
    assign upd          = s1_valid_q && (state_q == S_RUN) && !clr;

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        len_d      = len_q;
        fill_d     = fill_q;
        wptr_d     = wptr_q;
        s1_valid_d = 1'b0;
        s1_inc_d   = s1_inc_q;
        s1_evict_d = s1_evict_q;
        if (clr) begin
            state_d = S_CLEAR;
            sweep_d = '0;
            len_d   = len_sane;
            fill_d  = '0;
            wptr_d  = '0;
        end else if (state_q == S_CLEAR) begin
            sweep_d = sweep_q + DATA_SIZE'(1);
            if (sweep_q == DATA_SIZE'(DATA_NUM - 1)) begin
                state_d = S_RUN;
            end
        end else if (accept) begin
            s1_valid_d = 1'b1;
            s1_inc_d   = bus.in_data;
            s1_evict_d = evict_now;
            wptr_d     = wptr_q + ADDR_SIZE'(1);
            if (!evict_now) begin
                fill_d = fill_q + LEN_SIZE'(1);
            end
        end
        full_d = (fill_d == len_d);
    end

    // Each bin takes its whole net change in one cycle, so back-to-back hits on the same
    // bin always see the freshly written value and need no separate bypass path.
    always_comb begin
        for (int i = 0; i < DATA_NUM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (state_q == S_CLEAR) begin
                if (sweep_q == DATA_SIZE'(i)) begin
                    cnt_d[i] = '0;
                end
            end else if (upd) begin
                if ((s1_inc_q == DATA_SIZE'(i)) && !(s1_evict_q && fifo_rdata_q == DATA_SIZE'(i))) begin
                    cnt_d[i] = cnt_q[i] + LEN_SIZE'(1);
                end else if (s1_evict_q && (fifo_rdata_q == DATA_SIZE'(i)) && (s1_inc_q != DATA_SIZE'(i))) begin
                    cnt_d[i] = cnt_q[i] - LEN_SIZE'(1);
                end
            end
        end
    end

    always_comb begin
        rd_p_valid_d = bus.rd_req;
        rd_p_bin_d   = bus.rd_bin;
        rd_valid_d   = rd_p_valid_q;
        rd_count_d   = rd_p_valid_q ? cnt_q[rd_p_bin_q] : rd_count_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_CLEAR;
            sweep_q      <= '0;
            len_q        <= LEN_SIZE'(MAX_LEN);
            fill_q       <= '0;
            wptr_q       <= '0;
            full_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_inc_q     <= '0;
            s1_evict_q   <= 1'b0;
            rd_p_valid_q <= 1'b0;
            rd_p_bin_q   <= '0;
            rd_valid_q   <= 1'b0;
            rd_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            len_q        <= len_d;
            fill_q       <= fill_d;
            wptr_q       <= wptr_d;
            full_q       <= full_d;
            s1_valid_q   <= s1_valid_d;
            s1_inc_q     <= s1_inc_d;
            s1_evict_q   <= s1_evict_d;
            rd_p_valid_q <= rd_p_valid_d;
            rd_p_bin_q   <= rd_p_bin_d;
            rd_valid_q   <= rd_valid_d;
            rd_count_q   <= rd_count_d;
        end
    end

    // Bin storage is zeroed by the clear sweep rather than by reset.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wptr_q] <= bus.in_data;
        end
        fifo_rdata_q <= fifo_mem[rd_addr];
    end

    assign inc_ovf = upd && !(s1_evict_q && fifo_rdata_q == s1_inc_q) && (cnt_q[s1_inc_q] >= len_q);
    assign dec_unf = upd && s1_evict_q && (fifo_rdata_q != s1_inc_q) && (cnt_q[fifo_rdata_q] == '0);

    count_range_a: assert property (@(posedge clk) disable iff (!rstn) !(inc_ovf || dec_unf));

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_count = rd_count_q;
    assign win_full     = full_q;
    assign fill_cnt     = fill_q;
    assign busy         = (state_q == S_CLEAR);
endmodule

// File: tb/tb_sliding_histogram_cfg.sv
// Directed and random stimulus for sliding_histogram_cfg; readbacks are scored against
// a queue-based window model with the old/new tolerance for recent updates.
module tb_sliding_histogram_cfg;
    localparam int DS = 4;
    localparam int DN = 16;
    localparam int ML = 64;
    localparam int AS = 6;
    localparam int LS = 7;

    typedef struct packed {
        int           bin;
        int           due;
        logic [LS-1:0] v0;
        logic [LS-1:0] v1;
        logic [LS-1:0] v2;
        logic [LS-1:0] v3;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic [LS-1:0] win_len = '0;
    logic          win_full;
    logic [LS-1:0] fill_cnt;
    logic          busy;

    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    int      mcnt [DN];
    int      snap [4][DN];
    int      win_q [$];
    int      mlen = ML;
    int      clr_rem = DN;
    rd_exp_t sb [$];

    sliding_histogram_cfg_if #(.DATA_SIZE(DS), .LEN_SIZE(LS)) bus ();

    sliding_histogram_cfg #(
        .DATA_SIZE(DS), .DATA_NUM(DN), .MAX_LEN(ML), .ADDR_SIZE(AS), .LEN_SIZE(LS)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .win_len  (win_len),
        .bus      (bus),
        .win_full (win_full),
        .fill_cnt (fill_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock interval: drive inputs, check registered status, advance the model.
    task automatic tick(input bit v, input int d, input bit rq, input int rb, input bit c);
        rd_exp_t e;
        int slot;
        bus.in_valid = v;
        bus.in_data  = d[DS-1:0];
        bus.rd_req   = rq;
        bus.rd_bin   = rb[DS-1:0];
        clr          = c;
        #1;
        if (rstn) begin
            chk("busy", busy, clr_rem > 0);
            chk("in_ready", bus.in_ready, (clr_rem == 0) && !c);
            chk("fill_cnt", fill_cnt, win_q.size());
            chk("win_full", win_full, win_q.size() == mlen);
            if (clr_rem > 0) clr_rem--;
        end
        if (c) begin
            clr_rem = DN;
            mlen = (win_len == 0 || win_len > ML) ? ML : int'(win_len);
            win_q.delete();
            for (int b = 0; b < DN; b++) mcnt[b] = 0;
        end else if (v) begin
            win_q.push_back(d);
            mcnt[d]++;
            if (win_q.size() > mlen) begin
                mcnt[win_q[0]]--;
                void'(win_q.pop_front());
            end
        end
        slot = cyc % 4;
        for (int b = 0; b < DN; b++) snap[slot][b] = mcnt[b];
        if (rq) begin
            e.bin = rb;
            e.due = cyc + 2;
            e.v0  = LS'(snap[(cyc + 4) % 4][rb]);
            e.v1  = LS'(snap[(cyc + 3) % 4][rb]);
            e.v2  = LS'(snap[(cyc + 2) % 4][rb]);
            e.v3  = LS'(snap[(cyc + 1) % 4][rb]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic feed(input int d);
        tick(1, d, 0, 0, 0);
    endtask

    task automatic do_clr(input int len);
        win_len = LS'(len);
        tick(0, 0, 0, 0, 1);
        idle(DN);
    endtask

    task automatic read_all();
        for (int b = 0; b < DN; b++) tick(0, 0, 1, b, 0);
        idle(3);
    endtask

    // Readback monitor: responses must arrive exactly two intervals after the request.
    always @(negedge clk) begin
        rd_exp_t e;
        if (rstn) begin
            if (bus.rd_valid === 1'b1) begin
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL rd_spurious observed=rd_valid expected=idle (cyc %0d)", cyc);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    total++;
                    assert (e.due == cyc) else begin
                        bad++;
                        $error("FAIL rd_latency observed=%0d expected=%0d", cyc, e.due);
                    end
                    total++;
                    assert (bus.rd_count === e.v0 || bus.rd_count === e.v1 ||
                            bus.rd_count === e.v2 || bus.rd_count === e.v3) else begin
                        bad++;
                        $error("FAIL rd_count bin=%0d observed=%0d expected=%0d (or %0d/%0d/%0d)",
                               e.bin, bus.rd_count, e.v3, e.v2, e.v1, e.v0);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                total++;
                assert (bus.rd_valid === 1'b1) else begin
                    bad++;
                    $error("FAIL rd_missing bin=%0d observed=%0b expected=1", e.bin, bus.rd_valid);
                end
            end
        end
    end

    initial begin
        for (int s = 0; s < 4; s++)
            for (int b = 0; b < DN; b++) snap[s][b] = 0;
        for (int b = 0; b < DN; b++) mcnt[b] = 0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_req   = 1'b0;
        bus.rd_bin   = '0;

        // Reset values
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_count", bus.rd_count, 0);
        chk("rst_win_full", win_full, 0);
        chk("rst_fill_cnt", fill_cnt, 0);
        chk("rst_busy", busy, 1);
        rstn = 1'b1;

        // Sweep takes 16 intervals, then every bin reads 0
        idle(DN);
        read_all();

        // win_len=4: 3,3,5,3 then 5 evicts the oldest 3
        do_clr(4);
        feed(3); feed(3); feed(5); feed(3);
        idle(3);
        read_all();
        feed(5);
        idle(3);
        read_all();

        // win_len=8: long same-bin run, then alternating 7/2
        do_clr(8);
        for (int i = 0; i < 100; i++) feed(7);
        idle(3);
        read_all();
        for (int i = 0; i < 8; i++) feed((i % 2 == 0) ? 7 : 2);
        idle(3);
        read_all();

        // win_len=0 means the full 64-sample window
        do_clr(0);
        for (int i = 0; i < ML; i++) feed(15);
        idle(3);
        read_all();
        feed(15);
        idle(3);
        read_all();

        // Length change in RUN is ignored until the next clr; clr lands mid-flight
        do_clr(10);
        win_len = LS'(5);
        for (int i = 0; i < 7; i++) feed($urandom_range(0, DN - 1));
        idle(3);
        read_all();
        for (int i = 0; i < 5; i++) feed($urandom_range(0, DN - 1));
        idle(1);
        do_clr(5);
        read_all();
        for (int i = 0; i < 7; i++) feed(i);
        idle(3);
        read_all();

        // Random streaming with a readback every interval
        for (int pass = 0; pass < 2; pass++) begin
            do_clr(pass == 0 ? 1 : 13);
            for (int i = 0; i < 300; i++)
                tick($urandom_range(0, 3) != 0, $urandom_range(0, DN - 1), 1,
                     $urandom_range(0, DN - 1), 0);
            idle(4);
        end
        read_all();

        idle(4);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
